strobe_gen_mc: RTL and testbench

Multi-channel, parametrised strobe generator for the FPGA sample pipeline. Each channel produces single-cycle strobes at a programmable divide ratio, with a programmable initial phase offset and either free-running or fixed-length burst mode. A shared sync pulse re-aligns all enabled channels so decimator, packetiser and debug taps can share one timebase. Configuration is captured per channel at arm time, so software may rewrite registers while a channel runs without glitching it.

---
 rtl/strobe_gen_mc.sv | 94 +++++++++
 tb/tb_strobe_gen_mc.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/strobe_gen_mc.sv
// Multi-channel strobe generator: per-channel divide, phase and burst,
// with a shared sync pulse that re-arms every enabled channel.
module strobe_gen_mc #(
    parameter int CHANNELS = 4,
    parameter int RATE_W   = 16,
    parameter int BURST_W  = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [CHANNELS-1:0]         enable,
    input  logic [CHANNELS*RATE_W-1:0]  rate,
    input  logic [CHANNELS*RATE_W-1:0]  phase,
    input  logic [CHANNELS-1:0]         burst_mode,
    input  logic [CHANNELS*BURST_W-1:0] burst_len,
    input  logic                        sync_in,
    output logic [CHANNELS-1:0]         strobe,
    output logic [CHANNELS-1:0]         done,
    output logic                        any_strobe
);

    typedef enum logic [1:0] {
        IDLE,
        PHASE,
        RUN,
        DONE
    } state_t;

    logic [CHANNELS-1:0] fire;

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            state_t               state;
            logic [RATE_W-1:0]    cnt;
            logic [RATE_W-1:0]    rate_q;
            logic [BURST_W-1:0]   left;
            logic                 mode_q;
            logic                 strobe_q;
            logic                 done_q;
            logic                 arm;
            logic                 counting;

            assign arm      = enable[i] && (sync_in || state == IDLE);
            assign counting = (state == PHASE) || (state == RUN);

            // Sync and disable both pre-empt a strobe due on this edge.
            assign fire[i] = enable[i] && !arm && counting
                           && (cnt == '0) && (!mode_q || left != '0);

            always_ff @(posedge clock) begin
                if (reset || !enable[i]) begin
                    state    <= IDLE;
                    strobe_q <= 1'b0;
                    done_q   <= 1'b0;
                    cnt      <= '0;
                end else if (arm) begin
                    cnt      <= phase[i*RATE_W +: RATE_W];
                    rate_q   <= rate[i*RATE_W +: RATE_W];
                    mode_q   <= burst_mode[i];
                    left     <= burst_len[i*BURST_W +: BURST_W];
                    strobe_q <= 1'b0;
                    done_q   <= 1'b0;
                    state    <= PHASE;
                end else if (counting) begin
                    if (cnt != '0) begin
                        cnt      <= cnt - RATE_W'(1);
                        strobe_q <= 1'b0;
                    end else if (fire[i]) begin
                        strobe_q <= 1'b1;
                        cnt      <= rate_q;
                        if (mode_q)
                            left <= left - BURST_W'(1);
                        state    <= RUN;
                    end else begin
                        strobe_q <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
            end

            assign strobe[i] = strobe_q;
            assign done[i]   = done_q;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset)
            any_strobe <= 1'b0;
        else
            any_strobe <= |fire;
    end

endmodule

// File: tb/tb_strobe_gen_mc.sv
// Scoreboard bench for strobe_gen_mc: directed stimulus pushes expected
// output vectors tagged with an edge number; a monitor pops and compares.
module tb_strobe_gen_mc;

    localparam int CH = 4;
    localparam int RW = 16;
    localparam int BW = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic [CH-1:0]    enable;
    logic [CH*RW-1:0] rate;
    logic [CH*RW-1:0] phase;
    logic [CH-1:0]    burst_mode;
    logic [CH*BW-1:0] burst_len;
    logic             sync_in;
    logic [CH-1:0]    strobe;
    logic [CH-1:0]    done;
    logic             any_strobe;

    strobe_gen_mc #(.CHANNELS(CH), .RATE_W(RW), .BURST_W(BW)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .rate       (rate),
        .phase      (phase),
        .burst_mode (burst_mode),
        .burst_len  (burst_len),
        .sync_in    (sync_in),
        .strobe     (strobe),
        .done       (done),
        .any_strobe (any_strobe)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned  at;
        logic [CH-1:0] str;
        logic [CH-1:0] dn;
        string        tag;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned edge_n = 0;
    int          n_pass = 0;
    int          n_total = 0;

    // Monitor: output after edge n is sampled 1ns after that edge.
    initial begin
        forever begin
            @(posedge clock);
            edge_n++;
            #1;
            for (int j = exp_q.size() - 1; j >= 0; j--) begin
                if (exp_q[j].at == edge_n) begin
                    n_total++;
                    if (strobe === exp_q[j].str && done === exp_q[j].dn
                        && any_strobe === (exp_q[j].str != '0))
                        n_pass++;
                    else
                        $display("FAIL %s edge %0d: strobe=%b done=%b any=%b, expected strobe=%b done=%b any=%b",
                                 exp_q[j].tag, edge_n, strobe, done, any_strobe,
                                 exp_q[j].str, exp_q[j].dn, exp_q[j].str != '0);
                    exp_q.delete(j);
                end else if (exp_q[j].at < edge_n) begin
                    n_total++;
                    $display("FAIL %s edge %0d: expectation never sampled, required at edge %0d",
                             exp_q[j].tag, edge_n, exp_q[j].at);
                    exp_q.delete(j);
                end
            end
        end
    end

    task automatic expect_at(input int off, input logic [CH-1:0] s,
                             input logic [CH-1:0] d, input string tag);
        exp_t e;
        e.at  = edge_n + off;
        e.str = s;
        e.dn  = d;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic cfg(input int ch, input int r, input int p,
                       input logic m, input int bl);
        rate[ch*RW +: RW]      = RW'(r);
        phase[ch*RW +: RW]     = RW'(p);
        burst_mode[ch]         = m;
        burst_len[ch*BW +: BW] = BW'(bl);
    endtask

    initial begin
        reset = 1'b1; enable = '0; rate = '0; phase = '0;
        burst_mode = '0; burst_len = '0; sync_in = 1'b0;
        step(1);
        expect_at(1, 4'b0000, 4'b0000, "reset");
        step(2);
        reset = 1'b0;
        step(1);

        // ch0 R=3 P=0 free-running: strobes at +2, +6, +10
        cfg(0, 3, 0, 1'b0, 0);
        enable = 4'b0001;
        for (int o = 1; o <= 11; o++)
            expect_at(o, (o >= 2 && (o - 2) % 4 == 0) ? 4'b0001 : 4'b0000,
                      4'b0000, "free_r3");
        step(11);
        enable = '0;
        expect_at(1, 4'b0000, 4'b0000, "disable");
        step(2);

        // ch1 R=4 P=2 burst 3: strobes +4 +9 +14, done from +19
        cfg(1, 4, 2, 1'b1, 3);
        enable = 4'b0010;
        for (int o = 1; o <= 22; o++)
            expect_at(o, (o == 4 || o == 9 || o == 14) ? 4'b0010 : 4'b0000,
                      (o >= 19) ? 4'b0010 : 4'b0000, "burst3");
        step(22);
        enable = '0;
        expect_at(1, 4'b0000, 4'b0000, "done_clear");
        step(2);

        // ch2 R=0 free-running: high from +2 onward
        cfg(2, 0, 0, 1'b0, 0);
        enable = 4'b0100;
        for (int o = 1; o <= 7; o++)
            expect_at(o, (o >= 2) ? 4'b0100 : 4'b0000, 4'b0000, "free_r0");
        step(7);
        enable = '0;
        step(2);

        // ch2 R=0 burst 5: high +2..+6, done from +7
        cfg(2, 0, 0, 1'b1, 5);
        enable = 4'b0100;
        for (int o = 1; o <= 9; o++)
            expect_at(o, (o >= 2 && o <= 6) ? 4'b0100 : 4'b0000,
                      (o >= 7) ? 4'b0100 : 4'b0000, "burst_r0");
        step(9);
        enable = '0;
        step(2);

        // four channels R=7 phases 0..3; sync edge at +10 suppresses ch0
        for (int c = 0; c < CH; c++)
            cfg(c, 7, c, 1'b0, 0);
        enable = 4'b1111;
        for (int o = 1; o <= 20; o++) begin
            logic [CH-1:0] s;
            s = '0;
            for (int c = 0; c < CH; c++) begin
                if (o < 10)
                    s[c] = (o >= 2 + c) && ((o - 2 - c) % 8 == 0);
                else if (o > 10)
                    s[c] = (o >= 11 + c) && ((o - 11 - c) % 8 == 0);
            end
            expect_at(o, s, 4'b0000, "sync");
        end
        step(9);
        sync_in = 1'b1;
        step(1);
        sync_in = 1'b0;
        step(10);
        enable = '0;
        step(2);

        // rate rewritten 3->9 mid-run: period stays 4 until re-enable
        cfg(0, 3, 0, 1'b0, 0);
        enable = 4'b0001;
        for (int o = 1; o <= 30; o++) begin
            logic hit;
            if (o <= 15)
                hit = (o >= 2) && ((o - 2) % 4 == 0);
            else
                hit = (o == 18) || (o == 28);
            expect_at(o, hit ? 4'b0001 : 4'b0000, 4'b0000, "rate_rewrite");
        end
        step(3);
        rate[0 +: RW] = RW'(9);
        step(12);
        enable = '0;
        step(1);
        enable = 4'b0001;
        step(14);
        enable = '0;
        step(2);

        // reset mid-burst on ch1 after its first strobe at +4
        cfg(1, 4, 2, 1'b1, 3);
        enable = 4'b0010;
        for (int o = 1; o <= 8; o++)
            expect_at(o, (o == 4) ? 4'b0010 : 4'b0000, 4'b0000, "reset_mid");
        step(6);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        enable = '0;
        step(2);

        // burst_len=0, P=4 on ch3: no strobe, done from +6
        cfg(3, 2, 4, 1'b1, 0);
        enable = 4'b1000;
        for (int o = 1; o <= 8; o++)
            expect_at(o, 4'b0000, (o >= 6) ? 4'b1000 : 4'b0000, "burst0");
        step(8);
        enable = '0;
        step(3);

        if (exp_q.size() != 0) begin
            n_total += exp_q.size();
            $display("FAIL leftover: %0d expectations unsampled, required 0",
                     exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
